mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles, and MTHI/MTLO in a single cycle.
- Drives busy so the control unit can stall the PC.
- Its hi/lo outputs feed the writeback-select mux2 instances used for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved, no-op.
- a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  input  WIDTH  rt operand: multiplier or divisor.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after HI/LO are updated by a multiply or divide.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset:
  - rst is asynchronous, active-high.
  - Clears state to IDLE, hi=0, lo=0, done=0, busy=0, iteration counter=0 and all working registers.
  - Reset asserted mid-operation aborts the operation with no HI/LO write.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - start=1 with op in 0..3 at edge N: latch |a| and |b| (raw a/b for unsigned ops), latch the sign flags, count=0, go to CALC.
  - start=1 with op=4: hi<=a at edge N, stay IDLE, no done pulse.
  - start=1 with op=5: lo<=a at edge N, stay IDLE, no done pulse.
  - start=1 with op=6/7: ignored.
- CALC, one iteration per cycle for WIDTH cycles (edges N+1..N+WIDTH), then FIXUP:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIXUP, at edge N+WIDTH+1:
  - Apply sign correction and write hi/lo, return to IDLE.
  - done=1 for exactly the cycle after that edge.
  - Latency from start accept to result visible on hi/lo is WIDTH+1 = 33 cycles.
- busy is combinational from state: high from the cycle after edge N through the FIXUP cycle.
- start while busy is ignored; the control unit must hold the instruction until busy falls.
- hi/lo hold their previous values for the whole operation and change only at the FIXUP edge.
- Signed multiply: the product is negated when sign(a) XOR sign(b) = 1. {hi,lo} is the full 64-bit product.
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient is truncated toward zero.
  - Remainder sign follows the dividend.
- Divide by zero (b=0), signed or unsigned: lo=all ones, hi=a. The full latency still applies.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Operands a/b need not remain stable after the accept edge.

Decomposition:
- Shared package (mips_defs) holds:
  - MDU op encodings as localparams (MDU_MULT..MDU_MTLO).
  - State encodings for IDLE/CALC/FIXUP.
- Optional single sub-module mdu_divstep: combinational trial-subtract/shift for one restoring-division step.
- The multiply step stays inline.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done one cycle.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; hi/lo unchanged until the FIXUP edge.
- DIV checks:
  - a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 -> lo=14, hi=2.
- Corner cases:
  - DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo update at each edge, busy=0, done=0. A start during busy is ignored, leaving the result unchanged.
- Reset abort: assert rst 10 cycles into MULTU -> immediately state IDLE, busy=0, hi=lo=0. A new DIVU after release completes correctly.

Source files
------------

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Module  : mips_defs
// Brief   : Shared MDU op encodings and FSM state type for the MIPS datapath.
// Revision: 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'd0,
        MDU_CALC  = 2'd1,
        MDU_FIXUP = 2'd2
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_divstep.sv
`default_nettype none
// ============================================================================
// Module  : mdu_divstep
// Brief   : One restoring-division step: shift in a dividend bit, trial-subtract.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dq,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dq
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    // i_rem < divisor, so the shifted partial remainder always fits in WIDTH+1 bits
    assign w_shifted = {i_rem, i_dq[WIDTH-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign w_fits    = ~w_diff[WIDTH+1];

    assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign o_dq  = {i_dq[WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module  : mdu_hilo
// Brief   : Iterative multiply/divide unit with architectural HI/LO registers.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_hilo
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_arith;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_dq;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept = (r_state == MDU_IDLE) && start;
    assign w_arith  = w_accept && (op <= MDU_DIVU);
    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_a_neg  = w_signed && a[WIDTH-1];
    assign w_b_neg  = w_signed && b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Shift-add: upper half accumulates, carry re-enters at the top on the shift
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    mdu_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_dq      (r_acc[WIDTH-1:0]),
        .i_divisor (r_mcand),
        .o_rem     (w_div_rem),
        .o_dq      (w_div_dq)
    );

    // A zero divisor naturally leaves |a| as remainder, so only the quotient is forced
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != MDU_IDLE);
        case (r_state)
            MDU_IDLE:  if (w_arith) w_state_next = MDU_CALC;
            MDU_CALC:  if (r_count == c_LAST) w_state_next = MDU_FIXUP;
            MDU_FIXUP: w_state_next = MDU_IDLE;
            default:   w_state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == MDU_FIXUP);
            case (r_state)
                MDU_IDLE: begin
                    if (w_arith) begin
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mcand  <= w_b_mag;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= op[1] && (b == '0);
                        r_count  <= '0;
                    end else if (w_accept && op == MDU_MTHI) begin
                        r_hi <= a;
                    end else if (w_accept && op == MDU_MTLO) begin
                        r_lo <= a;
                    end
                end
                MDU_CALC: begin
                    r_acc   <= r_is_div ? {w_div_rem, w_div_dq} : w_mul_next;
                    r_count <= r_count + 1'b1;
                end
                MDU_FIXUP: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_hilo
// Brief   : Self-checking bench for mdu_hilo against an arithmetic reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    mdu_hilo #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: what HI/LO must hold after each op
    function automatic void mdu_ref(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rh, output logic [31:0] rl);
        longint          sx, sy, sq, sr;
        longint unsigned up;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin up = {32'b0, x} * {32'b0, y}; p = up; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (y == 0) begin rl = '1; rh = x; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = '0; end
                else begin sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0]; end
            end
            3'd3: begin
                if (y == 0) begin rl = '1; rh = x; end
                else begin rl = x / y; rh = x % y; end
            end
            default: ;
        endcase
    endfunction

    // Cycle model: remaining busy cycles, pending result, done pulse
    logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
    int          m_left = 0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    if (op <= 3'd3) begin
                        mdu_ref(op, a, b, m_ph, m_pl);
                        m_left = WIDTH + 1;
                    end else if (op == 3'd4) m_hi = a;
                    else if (op == 3'd5) m_lo = a;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_ph; m_lo = m_pl; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cyc_hi",   hi, m_hi);
            check("cyc_lo",   lo, m_lo);
            check("cyc_busy", {31'b0, busy}, {31'b0, (m_left != 0)});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                          input bit inject);
        logic [31:0] ph, pl;
        int cnt;
        ph = m_hi;
        pl = m_lo;
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (inject && cnt == 5) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            if (cnt == 16) begin
                check({name, "_hold_hi"}, hi, ph);
                check({name, "_hold_lo"}, lo, pl);
            end
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, cnt, 33);
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        @(negedge clk);
        check({name, "_done_clr"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult",  3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_nb",3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("divu",  3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b1);
        run_op("div0",  3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0);
        run_op("div0n", 3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("divu0", 3'd3, 32'h8000_0001, 32'd0,         32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
        run_op("ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
        run_op("mult_pp",3'd0,32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);

        // MTHI then MTLO back to back
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(negedge clk);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_done", {31'b0, done}, 32'd0);
        op = 3'd6; a = 32'h5555_5555; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rsv_busy", {31'b0, busy}, 32'd0);
        check("rsv_hi", hi, 32'h1234_5678);
        check("rsv_lo", lo, 32'h9ABC_DEF0);

        // Reset abort in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_post", 3'd3, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
